seq_det_param: RTL and testbench
================================

Name: seq_det_param

Overview:
- Parametrised serial pattern detector, the next generation of the fixed 4-bit Mealy detector.
- Features: runtime-programmable pattern of PAT_W bits, overlapping/non-overlapping mode, input-enable gating, Mealy and registered match outputs, saturating match counter.
- Placement: FSM library, serial front end for framing/sync-word detection ahead of deserialisers.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, match counter width.
- PAT_RST, 4'b0110, pattern value after reset; width PAT_W; MSB is the first bit received.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  data_in is valid this cycle; when low, no state changes except load and clear.
- data_in  in  1  serial data bit.
- pat_in  in  PAT_W  new pattern value.
- load_pat  in  1  pulse: capture pat_in, flush history.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  Mealy, combinational: the current bit completes the pattern.
- match_q  out  1  match registered one cycle later.
- match_cnt  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  match_cnt is all-ones.

Behaviour:
Reset (async, rst_n=0):
- pat_q = PAT_RST.
- hist = 0; fill = 0.
- match_q = 0; match_cnt = 0; cnt_sat = 0.
- match = 0 because fill = 0.

State:
- hist: last PAT_W-1 accepted bits, newest in LSB.
- fill: count of valid history bits, 0..PAT_W-1; width $clog2(PAT_W).

match rule:
- match = en & ~load_pat & (fill == PAT_W-1) & ({hist, data_in} == pat_q).
- Zero-latency Mealy output.

Accepted bit (en=1, load_pat=0):
- hist <= {hist[PAT_W-3:0], data_in}.
- fill <= min(fill+1, PAT_W-1).

On match:
- overlap=1: history keeps shifting normally, so the next match can share bits.
- overlap=0: fill <= 0 and hist <= 0; the next match needs PAT_W fresh bits.

Other registers:
- match_q <= match every cycle; 1-cycle latency.
- match_cnt increments on match; holds at 2^CNT_W-1. cnt_sat is a registered compare.

load_pat:
- pat_q <= pat_in; hist <= 0; fill <= 0; match forced 0 that cycle.
- The data bit that cycle is discarded; match_cnt is unaffected.

cnt_clr:
- match_cnt <= 0, cnt_sat <= 0.
- If cnt_clr and match occur together, clear wins and the count is 0, not 1.

en=0:
- hist, fill and match_cnt hold.
- match = 0; match_q follows match next cycle.

Reset mid-stream:
- All state is discarded immediately; no partial match survives.
- The first match is possible only on the PAT_W-th accepted bit after rst_n deasserts.

overlap changes:
- Take effect on the next match; no flush.

Optional Feature:
Macro SEQDET_STICKY_EN.
- Defined:
  - Adds input sticky_clr (1) and output sticky (1).
  - sticky sets on match and holds until sticky_clr. If both occur in one cycle, set wins.
  - Reset value of sticky is 0.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg holds:
  - localparam SEQDET_PAT_W_MAX = 32;
  - function clog2 for the fill width;
  - typedef of the counter type parameterised via CNT_W at the use site;
  - default-pattern constant SEQDET_PAT_DEF = 4'b0110.
- One sub-module: seq_det_sat_cnt, a generic saturating up-counter with sync clear, clear-priority and a sat flag, reused by sibling FSM blocks.
- Shift/compare logic stays in the top module.

Test Plan:
- Reset, PAT_RST=0110, overlap=1, en=1, stream 0,1,1,0,1,1,0 → match high on the 4th and 7th bits; match_q one cycle after each; match_cnt=2.
- Same stream with overlap=0 → match only on the 4th bit; match_cnt=1.
- load_pat with pat_in=1011 together with en=1, then stream 1,0,1,1 → no match on the load cycle; match on the 4th following bit; earlier history ignored.
- en toggled low between bits of 0,1,1,0 → history holds while en=0; match on the final accepted 0; match=0 in every en=0 cycle.
- CNT_W=2, six matches, cnt_clr pulsed on the same cycle as a match → count saturates at 3 with cnt_sat=1; after the clear match_cnt=0 and cnt_sat=0.
- rst_n pulsed low after 0,1,1 (mid-pattern), then 0 → no match; match_cnt=0. With SEQDET_STICKY_EN, sticky stays 1 after a match until sticky_clr, and set wins on a coincident match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
package seq_det_pkg;

    localparam int SEQDET_PAT_W_MAX = 32;
    localparam int SEQDET_CNT_W_DEF = 8;
    localparam logic [3:0] SEQDET_PAT_DEF = 4'b0110;

    // Ceiling log2; sizes the history fill counter.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Generic saturating up-counter with synchronous clear (clear beats increment)
// and a registered all-ones flag.
module seq_det_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    typedef logic [W-1:0] cnt_t;

    cnt_t cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && (cnt != '1)) begin
            cnt_nxt = cnt + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sat <= &cnt_nxt;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with programmable pattern and match counter.
// Optional sticky match flag enabled by defining SEQDET_STICKY_EN.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = SEQDET_CNT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(SEQDET_PAT_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             data_in,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             load_pat,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
`ifdef SEQDET_STICKY_EN
    ,
    input  logic             sticky_clr,
    output logic             sticky
`endif
);

    localparam int FILL_W = clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    typedef logic [CNT_W-1:0] cnt_t;

    generate
        if (PAT_W < 2 || PAT_W > SEQDET_PAT_W_MAX) begin : g_bad_pat_w
            $error("seq_det_param: PAT_W out of range 2..32");
        end
    endgenerate

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-2:0]  hist;
    logic [PAT_W-2:0]  hist_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [PAT_W-1:0]  shifted;
    cnt_t              cnt_val;

    // Shifting through a full-width vector keeps the PAT_W=2 case legal.
    always_comb begin
        shifted  = {hist, data_in};
        match    = en & ~load_pat & (fill == FILL_MAX) & (shifted == pat_q);
        hist_nxt = hist;
        fill_nxt = fill;
        if (load_pat) begin
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (en) begin
            if (match && !overlap) begin
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                hist_nxt = shifted[PAT_W-2:0];
                fill_nxt = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= PAT_RST;
            hist    <= '0;
            fill    <= '0;
            match_q <= 1'b0;
        end else begin
            if (load_pat) begin
                pat_q <= pat_in;
            end
            hist    <= hist_nxt;
            fill    <= fill_nxt;
            match_q <= match;
        end
    end

    seq_det_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (match),
        .cnt   (cnt_val),
        .sat   (cnt_sat)
    );

    assign match_cnt = cnt_val;

`ifdef SEQDET_STICKY_EN
    // A coincident match wins over sticky_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else if (match) begin
            sticky <= 1'b1;
        end else if (sticky_clr) begin
            sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed, table-driven check of seq_det_param (8-bit and 2-bit counter builds).
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       data_in;
    logic [3:0] pat_in;
    logic       load_pat;
    logic       overlap;
    logic       cnt_clr;

    logic       match, match_q, cnt_sat;
    logic [7:0] match_cnt;
    logic       match2, match_q2, sat2;
    logic [1:0] cnt2;
`ifdef SEQDET_STICKY_EN
    logic       sticky_clr;
    logic       sticky, sticky2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_det_param #(.PAT_W(4), .CNT_W(8)) dut (
        .clk (clk), .rst_n (rst_n), .en (en), .data_in (data_in),
        .pat_in (pat_in), .load_pat (load_pat), .overlap (overlap),
        .cnt_clr (cnt_clr), .match (match), .match_q (match_q),
        .match_cnt (match_cnt), .cnt_sat (cnt_sat)
`ifdef SEQDET_STICKY_EN
        , .sticky_clr (sticky_clr), .sticky (sticky)
`endif
    );

    seq_det_param #(.PAT_W(4), .CNT_W(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .en (en), .data_in (data_in),
        .pat_in (pat_in), .load_pat (load_pat), .overlap (overlap),
        .cnt_clr (cnt_clr), .match (match2), .match_q (match_q2),
        .match_cnt (cnt2), .cnt_sat (sat2)
`ifdef SEQDET_STICKY_EN
        , .sticky_clr (sticky_clr), .sticky (sticky2)
`endif
    );

    typedef struct {
        logic       en;
        logic       d;
        logic       ld;
        logic [3:0] pat;
        logic       ovl;
        logic       clr;
        logic       m;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic d, input logic ld, input logic [3:0] p,
                       input logic o, input logic c, input logic m, input int n);
        vec_t v;
        v.en = e; v.d = d; v.ld = ld; v.pat = p; v.ovl = o; v.clr = c; v.m = m; v.cnt = n;
        vecs.push_back(v);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int exp2;
        en = v.en; data_in = v.d; load_pat = v.ld; pat_in = v.pat;
        overlap = v.ovl; cnt_clr = v.clr;
        @(negedge clk);
        check($sformatf("match[%0d]", idx), 32'(match), 32'(v.m));
        check($sformatf("match2[%0d]", idx), 32'(match2), 32'(v.m));
        @(posedge clk);
        #1;
        exp2 = (v.cnt > 3) ? 3 : v.cnt;
        check($sformatf("match_q[%0d]", idx), 32'(match_q), 32'(v.m));
        check($sformatf("match_cnt[%0d]", idx), 32'(match_cnt), v.cnt);
        check($sformatf("cnt_sat[%0d]", idx), 32'(cnt_sat), 32'(0));
        check($sformatf("cnt2[%0d]", idx), 32'(cnt2), exp2);
        check($sformatf("sat2[%0d]", idx), 32'(sat2), (exp2 == 3) ? 32'(1) : 32'(0));
    endtask

    task automatic step(input string tag, input logic e, input logic d, input logic exp_m);
        en = e; data_in = d; load_pat = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        check(tag, 32'(match), 32'(exp_m));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t lv;
        rst_n = 1'b0; en = 1'b0; data_in = 1'b0; pat_in = 4'b0000;
        load_pat = 1'b0; overlap = 1'b1; cnt_clr = 1'b0;
`ifdef SEQDET_STICKY_EN
        sticky_clr = 1'b0;
`endif

        // T1: overlapping, reset pattern 0110, stream 0110110
        add(1,0,0,4'h0,1,0,0,0); add(1,1,0,4'h0,1,0,0,0); add(1,1,0,4'h0,1,0,0,0);
        add(1,0,0,4'h0,1,0,1,1); add(1,1,0,4'h0,1,0,0,1); add(1,1,0,4'h0,1,0,0,1);
        add(1,0,0,4'h0,1,0,1,2);
        // T2: flush + clear, non-overlapping, same stream
        add(0,0,1,4'b0110,0,1,0,0);
        add(1,0,0,4'h0,0,0,0,0); add(1,1,0,4'h0,0,0,0,0); add(1,1,0,4'h0,0,0,0,0);
        add(1,0,0,4'h0,0,0,1,1); add(1,1,0,4'h0,0,0,0,1); add(1,1,0,4'h0,0,0,0,1);
        add(1,0,0,4'h0,0,0,0,1);
        // T3: load 1011 with en=1 (bit discarded), then 1011
        add(1,1,1,4'b1011,1,1,0,0);
        add(1,1,0,4'h0,1,0,0,0); add(1,0,0,4'h0,1,0,0,0); add(1,1,0,4'h0,1,0,0,0);
        add(1,1,0,4'h0,1,0,1,1);
        // T4: en gaps inside 0110
        add(0,0,1,4'b0110,1,1,0,0);
        add(1,0,0,4'h0,1,0,0,0); add(0,1,0,4'h0,1,0,0,0); add(1,1,0,4'h0,1,0,0,0);
        add(0,0,0,4'h0,1,0,0,0); add(1,1,0,4'h0,1,0,0,0); add(0,0,0,4'h0,1,0,0,0);
        add(1,0,0,4'h0,1,0,1,1); add(0,0,0,4'h0,1,0,0,1);
        // T5: six overlapping matches; 2-bit build saturates; clear on the sixth
        add(0,0,1,4'b0110,1,1,0,0);
        add(1,0,0,4'h0,1,0,0,0); add(1,1,0,4'h0,1,0,0,0); add(1,1,0,4'h0,1,0,0,0);
        add(1,0,0,4'h0,1,0,1,1);
        add(1,1,0,4'h0,1,0,0,1); add(1,1,0,4'h0,1,0,0,1); add(1,0,0,4'h0,1,0,1,2);
        add(1,1,0,4'h0,1,0,0,2); add(1,1,0,4'h0,1,0,0,2); add(1,0,0,4'h0,1,0,1,3);
        add(1,1,0,4'h0,1,0,0,3); add(1,1,0,4'h0,1,0,0,3); add(1,0,0,4'h0,1,0,1,4);
        add(1,1,0,4'h0,1,0,0,4); add(1,1,0,4'h0,1,0,0,4); add(1,0,0,4'h0,1,0,1,5);
        add(1,1,0,4'h0,1,0,0,5); add(1,1,0,4'h0,1,0,0,5); add(1,0,0,4'h0,1,1,1,0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_match", 32'(match), 32'(0));
        check("rst_match_q", 32'(match_q), 32'(0));
        check("rst_cnt", 32'(match_cnt), 32'(0));
        check("rst_sat", 32'(cnt_sat), 32'(0));
        check("rst_sat2", 32'(sat2), 32'(0));
`ifdef SEQDET_STICKY_EN
        check("rst_sticky", 32'(sticky), 32'(0));
`endif
        rst_n = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // T6: reset in the middle of a partial pattern
        lv.en = 0; lv.d = 0; lv.ld = 1; lv.pat = 4'b1011; lv.ovl = 1; lv.clr = 1; lv.m = 0; lv.cnt = 0;
        apply_vec(lv, 900);
        step("t6_pre1", 1, 1, 0);
        step("t6_pre2", 1, 0, 0);
        step("t6_pre3", 1, 1, 0);
        rst_n = 1'b0; en = 1'b1; data_in = 1'b1;
        #2;
        check("t6_rst_match", 32'(match), 32'(0));
        check("t6_rst_cnt", 32'(match_cnt), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("t6_b1", 1, 0, 0);
        step("t6_b2", 1, 1, 0);
        step("t6_b3", 1, 1, 0);
        step("t6_b4", 1, 0, 1);
        check("t6_cnt", 32'(match_cnt), 32'(1));

`ifdef SEQDET_STICKY_EN
        check("sticky_set", 32'(sticky), 32'(1));
        step("sticky_idle", 0, 0, 0);
        check("sticky_hold", 32'(sticky), 32'(1));
        sticky_clr = 1'b1;
        step("sticky_clr_cyc", 0, 0, 0);
        sticky_clr = 1'b0;
        check("sticky_cleared", 32'(sticky), 32'(0));
        step("sticky_b1", 1, 1, 0);
        step("sticky_b2", 1, 1, 0);
        sticky_clr = 1'b1;
        step("sticky_b3", 1, 0, 1);
        sticky_clr = 1'b0;
        check("sticky_set_wins", 32'(sticky), 32'(1));
`endif

        en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
